queue_fifo_param: RTL and testbench
===================================

Name: queue_fifo_param

Overview:
- Parametrised synchronous FIFO for the bank-line queue path. It is the next generation of the 16-entry, 8-bit ticket buffer.
- Width and depth are generic, and the occupancy threshold is programmable at run time.
- Adds the following:
  - registered read data;
  - an occupancy count;
  - write-through-when-full on a simultaneous read;
  - sticky error flags with explicit clear;
  - a synchronous flush.
- Sits between the ticket-entry encoders and the 7-segment display drivers.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 4, address width; depth = 2**ADDR_W entries
CNT_W, ADDR_W+1, count/pointer width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
wr  in  1  write request
rd  in  1  read request
data_in  in  DATA_W  write data
data_out  out  DATA_W  registered read data
thr_level  in  CNT_W  programmable threshold level
flush  in  1  synchronous flush of contents and flags
clr_flags  in  1  synchronous clear of sticky overflow/underflow
fifo_full  out  1  count == 2**ADDR_W
fifo_empty  out  1  count == 0
fifo_threshold  out  1  count >= thr_level
fifo_overflow  out  1  sticky: write rejected
fifo_underflow  out  1  sticky: read rejected
count  out  CNT_W  current occupancy
peak_count  out  CNT_W  maximum occupancy (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous):
  - wptr, rptr, count, data_out, overflow, underflow, peak all go to 0.
  - fifo_empty=1, fifo_full=0.
  - fifo_threshold = (thr_level==0).
- Pointers:
  - wptr and rptr are CNT_W bits; the memory index is [ADDR_W-1:0].
  - The MSB toggles on wrap, and wrap is natural modulo 2**CNT_W.
- Flags are combinational:
  - full = (MSBs differ) & (low bits equal).
  - empty = pointers equal.
  - count = wptr - rptr, in CNT_W bits.
- Accept rules:
  - rd_acc = rd & ~empty.
  - wr_acc = wr & (~full | rd). A write is accepted while full only when a read is presented in the same cycle.
- Simultaneous wr and rd:
  - Full: both are accepted, count is unchanged, and the new word is written into the freed slot.
  - Empty: only the write is accepted. The read is rejected, underflow is set, and there is no fall-through.
  - Otherwise: both are accepted and count is unchanged.
- Read latency: 1 cycle.
  - On a clock edge where rd_acc=1, data_out <= mem[rptr] and rptr increments.
  - Otherwise data_out holds its value.
- Memory write: on a clock edge where wr_acc=1, mem[wptr] <= data_in and wptr increments. Memory contents are not reset.
- fifo_overflow:
  - Set on a clock edge where wr & full & ~rd.
  - Cleared only by clr_flags or flush.
  - If a set condition and clr_flags occur in the same cycle, the set wins.
- fifo_underflow:
  - Set on a clock edge where rd & empty.
  - Cleared only by clr_flags or flush.
  - If a set condition and clr_flags occur in the same cycle, the set wins.
- flush:
  - At the next clock edge: wptr=rptr=0, overflow=underflow=0, peak=0. data_out holds its value.
  - flush has priority over wr and rd in the same cycle; both are ignored and no flags are set.
- fifo_threshold:
  - count >= thr_level, combinational, and tracks thr_level changes immediately.
  - thr_level > 2**ADDR_W means the output never asserts.
- Asserting rst_n mid-transfer aborts the operation. No partial pointer update is permitted.

Optional Feature:
- Macro QUEUE_FIFO_PEAK_EN.
- Defined:
  - peak_count is a register updated each edge to max(peak_count, next count).
  - Reset to 0 by rst_n, flush, or clr_flags. If clr_flags and an update occur together, the register loads the next count.
- Undefined:
  - No peak register is synthesised and peak_count is tied to 0.
  - All other behaviour is identical.

Test Plan:
All scenarios use DATA_W=8, ADDR_W=4.
- Reset, then write 0x11..0x1F, 0x10 (16 words) -> fifo_full=1, count=16, overflow=0. A 17th wr with rd=0 -> overflow=1 next cycle, count stays 16, stored data unchanged.
- Full FIFO, wr=1 rd=1 with data_in=0xAA -> data_out=0x11 one cycle later, count=16. After 16 further reads the last word out is 0xAA, then empty=1.
- Empty FIFO, rd=1 -> underflow=1 and data_out unchanged. Then clr_flags=1 for 1 cycle -> underflow=0. Simultaneous rd=1 and clr_flags=1 on empty -> underflow stays 1.
- thr_level=5; write 4 words -> threshold=0; write a 5th -> threshold=1. Change thr_level to 0 -> threshold=1 immediately.
- Write 7 words, flush=1 with wr=1 rd=1 -> next cycle count=0, empty=1, flags=0, no write taken. Then write 0x3C and read -> 0x3C.
- With QUEUE_FIFO_PEAK_EN: write 9, read 6, write 2 -> peak_count=9. clr_flags -> peak_count=5. Without the macro, peak_count=0 throughout.

Source files
------------

// File: rtl/queue_fifo_param.sv
// rtl/queue_fifo_param.sv - parametrised FIFO with threshold, sticky flags and flush
// Optional peak-occupancy register enabled by QUEUE_FIFO_PEAK_EN.
module queue_fifo_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    input  logic [CNT_W-1:0]  thr_level,
    input  logic              flush,
    input  logic              clr_flags,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              fifo_threshold,
    output logic              fifo_overflow,
    output logic              fifo_underflow,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  peak_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  wptr;
    logic [CNT_W-1:0]  rptr;
    logic              rd_acc;
    logic              wr_acc;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count          = wptr - rptr;
    assign fifo_empty     = (wptr == rptr);
    assign fifo_full      = (wptr[CNT_W-1] != rptr[CNT_W-1]) &&
                            (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    assign fifo_threshold = (count >= thr_level);

    assign rd_acc = rd & ~fifo_empty & ~flush;
    assign wr_acc = wr & (~fifo_full | rd) & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr           <= '0;
            rptr           <= '0;
            data_out       <= '0;
            fifo_overflow  <= 1'b0;
            fifo_underflow <= 1'b0;
        end else if (flush) begin
            wptr           <= '0;
            rptr           <= '0;
            fifo_overflow  <= 1'b0;
            fifo_underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + CNT_W'(1);
            end
            if (rd_acc) begin
                data_out <= mem[rptr[ADDR_W-1:0]];
                rptr     <= rptr + CNT_W'(1);
            end
            // A new error in the same cycle as clr_flags keeps the flag set.
            if (wr & fifo_full & ~rd) begin
                fifo_overflow <= 1'b1;
            end else if (clr_flags) begin
                fifo_overflow <= 1'b0;
            end
            if (rd & fifo_empty) begin
                fifo_underflow <= 1'b1;
            end else if (clr_flags) begin
                fifo_underflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && rst_n) begin
            mem[wptr[ADDR_W-1:0]] <= data_in;
        end
    end

`ifdef QUEUE_FIFO_PEAK_EN
    logic [CNT_W-1:0] next_count;
    logic [CNT_W-1:0] peak;

    always_comb begin
        next_count = count;
        if (wr_acc && !rd_acc) begin
            next_count = count + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            next_count = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak <= '0;
        end else if (flush) begin
            peak <= '0;
        end else if (clr_flags || (next_count > peak)) begin
            peak <= next_count;
        end
    end

    assign peak_count = peak;
`else
    assign peak_count = '0;
`endif

endmodule

// File: tb/tb_queue_fifo_param.sv
// tb/tb_queue_fifo_param.sv - queue-model checked bench for queue_fifo_param
module tb_queue_fifo_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic       flush = 1'b0;
    logic       clr_flags = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [4:0] thr_level = 5'd0;
    logic [7:0] data_out;
    logic       fifo_full, fifo_empty, fifo_threshold, fifo_overflow, fifo_underflow;
    logic [4:0] count, peak_count;

    int n_tests = 0;
    int n_fail  = 0;

    queue_fifo_param #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .data_in(data_in),
        .data_out(data_out), .thr_level(thr_level), .flush(flush),
        .clr_flags(clr_flags), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_threshold(fifo_threshold), .fifo_overflow(fifo_overflow),
        .fifo_underflow(fifo_underflow), .count(count), .peak_count(peak_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: a plain queue of words plus flag bits.
    logic [7:0] q[$];
    logic [7:0] m_dout;
    bit         m_ovf, m_udf;
    int         m_peak;
    int         m_n;
    bit         m_full, m_empty;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_dout = 8'h00;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
            m_peak = 0;
        end else if (flush) begin
            q.delete();
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
            m_peak = 0;
        end else begin
            m_n     = q.size();
            m_full  = (m_n == 16);
            m_empty = (m_n == 0);
            if (rd && !m_empty) m_dout = q.pop_front();
            if (wr && (!m_full || rd)) q.push_back(data_in);
            if (wr && m_full && !rd) m_ovf = 1'b1;
            else if (clr_flags) m_ovf = 1'b0;
            if (rd && m_empty) m_udf = 1'b1;
            else if (clr_flags) m_udf = 1'b0;
`ifdef QUEUE_FIFO_PEAK_EN
            if (clr_flags || q.size() > m_peak) m_peak = q.size();
`endif
        end
    end

    always @(negedge clk) begin
        check("data_out", int'(data_out), int'(m_dout));
        check("count", int'(count), q.size());
        check("full", int'(fifo_full), int'(q.size() == 16));
        check("empty", int'(fifo_empty), int'(q.size() == 0));
        check("threshold", int'(fifo_threshold), int'(q.size() >= int'(thr_level)));
        check("overflow", int'(fifo_overflow), int'(m_ovf));
        check("underflow", int'(fifo_underflow), int'(m_udf));
        check("peak_count", int'(peak_count), m_peak);
    end

    task automatic cyc(input logic w, input logic r, input logic [7:0] d,
                       input logic f = 1'b0, input logic c = 1'b0);
        wr = w; rd = r; data_in = d; flush = f; clr_flags = c;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_flags = 1'b0;
    endtask

    int exp_peak9, exp_peak5;

    initial begin
`ifdef QUEUE_FIFO_PEAK_EN
        exp_peak9 = 9;
        exp_peak5 = 5;
`else
        exp_peak9 = 0;
        exp_peak5 = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(fifo_empty), 1);
        check("rst_full", int'(fifo_full), 0);
        check("rst_thr_zero", int'(fifo_threshold), 1);
        check("rst_dout", int'(data_out), 0);
        rst_n = 1'b1;
        thr_level = 5'd8;

        // Fill with 0x11..0x1F, 0x10 then try a rejected 17th write.
        for (int i = 1; i <= 16; i++) cyc(1, 0, 8'(8'h10 + (i % 16)));
        check("fill_full", int'(fifo_full), 1);
        check("fill_count", int'(count), 16);
        check("fill_ovf", int'(fifo_overflow), 0);
        cyc(1, 0, 8'h55);
        check("ovf_set", int'(fifo_overflow), 1);
        check("ovf_count", int'(count), 16);

        cyc(1, 1, 8'hAA);
        check("wt_dout", int'(data_out), 8'h11);
        check("wt_count", int'(count), 16);
        for (int i = 0; i < 16; i++) cyc(0, 1, 8'h00);
        check("drain_last", int'(data_out), 8'hAA);
        check("drain_empty", int'(fifo_empty), 1);

        cyc(0, 1, 8'h00);
        check("udf_set", int'(fifo_underflow), 1);
        check("udf_dout_hold", int'(data_out), 8'hAA);
        cyc(0, 0, 8'h00, 0, 1);
        check("udf_clr", int'(fifo_underflow), 0);
        check("ovf_clr", int'(fifo_overflow), 0);
        cyc(0, 1, 8'h00, 0, 1);
        check("udf_set_wins", int'(fifo_underflow), 1);

        thr_level = 5'd5;
        for (int i = 0; i < 4; i++) cyc(1, 0, 8'(8'h20 + i));
        check("thr_below", int'(fifo_threshold), 0);
        cyc(1, 0, 8'h24);
        check("thr_at", int'(fifo_threshold), 1);
        thr_level = 5'd0;
        #1;
        check("thr_zero_now", int'(fifo_threshold), 1);
        thr_level = 5'd17;
        #1;
        check("thr_above_depth", int'(fifo_threshold), 0);
        thr_level = 5'd5;

        cyc(1, 0, 8'h25);
        cyc(1, 0, 8'h26);
        check("pre_flush_count", int'(count), 7);
        cyc(1, 1, 8'h77, 1, 0);
        check("flush_count", int'(count), 0);
        check("flush_empty", int'(fifo_empty), 1);
        check("flush_udf", int'(fifo_underflow), 0);
        check("flush_ovf", int'(fifo_overflow), 0);
        cyc(1, 0, 8'h3C);
        cyc(0, 1, 8'h00);
        check("post_flush_dout", int'(data_out), 8'h3C);

        for (int i = 0; i < 9; i++) cyc(1, 0, 8'(8'h40 + i));
        for (int i = 0; i < 6; i++) cyc(0, 1, 8'h00);
        for (int i = 0; i < 2; i++) cyc(1, 0, 8'(8'h50 + i));
        check("peak_hold", int'(peak_count), exp_peak9);
        check("peak_cnt5", int'(count), 5);
        cyc(0, 0, 8'h00, 0, 1);
        check("peak_clr", int'(peak_count), exp_peak5);

        // Asynchronous reset in the middle of a cycle with wr and rd pending.
        wr = 1'b1; rd = 1'b1; data_in = 8'h99;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", int'(count), 0);
        check("async_rst_dout", int'(data_out), 0);
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0;
        rst_n = 1'b1;
        repeat (2) cyc(0, 0, 8'h00);
        check("after_rst_empty", int'(fifo_empty), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
